rr_mux_8x1: RTL and testbench

- 8-channel round-robin concentrator. Eight valid/ready input channels are merged onto one registered output stream.
- Each output beat carries the channel index on out_sel, so a downstream 1-to-8 demultiplexer can route the beat back to its destination.
- This block is the transmit-side counterpart of the 1x8 demux path. It sits between the per-channel producers and the shared serial/bus stage.

---
 rtl/rr_mux_8x1_pkg.sv | 26 ++
 rtl/rr_mux_8x1_arbiter.sv | 32 +++
 rtl/rr_mux_8x1.sv | 68 ++++++
 tb/tb_rr_mux_8x1.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_8x1_pkg.sv
// Shared channel definitions for the 8-channel round-robin concentrator and
// its companion 1x8 demux.
//   N_CH          number of channels (fixed at 8)
//   SEL_W         channel index width
//   DATA_W_DEF    default per-channel data width
//   onehot_to_idx one-hot (or zero) 8-bit vector -> 3-bit channel index
package rr_mux_8x1_pkg;

  localparam int unsigned N_CH       = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [N_CH-1:0]  ch_vec_t;
  typedef logic [SEL_W-1:0] ch_idx_t;

  // OR of the indices of all set bits; exact for one-hot input, 0 for zero.
  function automatic ch_idx_t onehot_to_idx(input ch_vec_t oh);
    ch_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (oh[i]) idx = idx | ch_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_mux_8x1_arbiter.sv
// rr_arbiter_8: combinational 8-way round-robin arbiter.
//   req     request vector
//   ptr     highest-priority channel this cycle
//   gnt     one-hot (or zero) grant: first requester at ptr, ptr+1, ... mod 8
//   gnt_idx index of the granted channel (0 when no grant)
module rr_arbiter_8
  import rr_mux_8x1_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [2*N_CH-1:0] req_dbl;
  logic [2*N_CH-1:0] gnt_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [N_CH-1:0]   pick_rot;

  always_comb begin
    // Rotate right by ptr so the pointer channel lands at bit 0.
    req_dbl  = {req, req} >> ptr;
    req_rot  = req_dbl[N_CH-1:0];
    // Isolate the lowest set bit: fixed-priority pick in rotated space.
    pick_rot = req_rot & (~req_rot + {{(N_CH-1){1'b0}}, 1'b1});
    // Rotate left by ptr to return to channel numbering.
    gnt_dbl  = {pick_rot, pick_rot} << ptr;
    gnt      = gnt_dbl[2*N_CH-1:N_CH];
    gnt_idx  = onehot_to_idx(gnt);
  end

endmodule

// File: rtl/rr_mux_8x1.sv
// rr_mux_8x1: 8-channel round-robin concentrator onto one registered stream.
//   clk, rst_n  clock, asynchronous active-low reset
//   ch_en       per-channel enable mask (disabled channels never granted)
//   in_valid    per-channel word available
//   in_data     channel i word at [i*DATA_W +: DATA_W]
//   in_ready    one-hot (or zero) accept strobe, combinational on in_valid
//   out_valid   output register holds a beat
//   out_data    beat data
//   out_sel     source channel of the beat
//   out_ready   downstream accepts the beat this cycle
module rr_mux_8x1
  import rr_mux_8x1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              load;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter_8 u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    load     = ~out_valid | out_ready;
    req      = in_valid & ch_en;
    in_ready = load ? gnt : '0;
    xfer     = |in_ready;
    sel_data = in_data[gnt_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      // Covers both an empty register and drain-and-refill in one edge.
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
      ptr       <= gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_8x1.sv
module tb_rr_mux_8x1;
  import rr_mux_8x1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch_en;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_ready;

  rr_mux_8x1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit loop_mode = 1'b0;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t      expq[$];
  logic [7:0] sinkq[8][$];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned ch);
    beat_t b;
    b.sel  = 3'(ch);
    b.data = 8'(8'h10 + ch);
    expq.push_back(b);
  endtask

  // Monitor: handshake sanity every cycle, and scoreboard pop on each
  // accepted output beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (((in_valid & ch_en) != 8'h00) && (!out_valid || out_ready))
        chk("in_ready_onehot", $countones(in_ready), 1);
      else
        chk("in_ready_idle", in_ready, 0);
      chk("in_ready_masked", in_ready & ~(in_valid & ch_en), 0);

      if (out_valid && out_ready) begin
        if (loop_mode) begin
          chk("sink_nonempty", int'(sinkq[out_sel].size() != 0), 1);
          if (sinkq[out_sel].size() != 0)
            chk("sink_data", out_data, sinkq[out_sel].pop_front());
        end else begin
          chk("beat_expected", int'(expq.size() != 0), 1);
          if (expq.size() != 0) begin
            beat_t e;
            e = expq.pop_front();
            chk("out_sel", out_sel, e.sel);
            chk("out_data", out_data, e.data);
          end
        end
      end
    end
  end

  int          rem[8];
  int          cycles;
  logic [7:0]  acc;

  initial begin
    ch_en     = 8'hFF;
    in_valid  = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);

    // Reset values
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    #2 rst_n = 1'b1;

    // All channels requesting: 0..7,0,1
    for (int i = 0; i < 8; i++) push(i);
    push(0);
    push(1);
    in_valid = 8'hFF;
    repeat (10) @(posedge clk);
    #1 in_valid = 8'h00;
    repeat (2) tick();

    // Backpressure: ptr=2, ch3 loaded then held 4 cycles, ch4 follows
    push(3);
    push(4);
    in_valid  = 8'h18;
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sel", out_sel, 3);
      chk("bp_out_data", out_data, 8'h13);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_grant", in_ready, 8'h10);
    tick();
    in_valid = 8'h00;
    repeat (2) tick();

    // Wrap and skip: ch5 moves ptr to 6, then {1,6} -> 6,1,6
    push(5);
    push(6);
    push(1);
    push(6);
    in_valid = 8'h20;
    tick();
    in_valid = 8'h42;
    repeat (3) tick();
    in_valid = 8'h00;
    repeat (2) tick();

    // Masking: ptr=7, only channels 0 and 2 enabled
    ch_en = 8'h05;
    for (int k = 0; k < 3; k++) begin
      push(0);
      push(2);
    end
    in_valid = 8'hFF;
    repeat (6) tick();
    in_valid = 8'h00;
    ch_en    = 8'hFF;
    repeat (2) tick();

    // Single requester granted every cycle
    repeat (3) push(0);
    in_valid = 8'h01;
    repeat (3) tick();
    in_valid = 8'h00;
    repeat (2) tick();

    // Reset mid-operation with a pending beat (ch1, ptr=1)
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    tick();
    in_valid = 8'h00;
    chk("pend_out_valid", out_valid, 1);
    chk("pend_out_sel", out_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_sel", out_sel, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 8'hFF;
    push(0);
    tick();
    in_valid = 8'h00;
    repeat (2) tick();
    chk("scoreboard_drained", expq.size(), 0);

    // Loopback: 100 random words per channel, random backpressure
    loop_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rem[i] = 100;
      in_data[i*8 +: 8] = 8'($urandom);
    end
    in_valid = 8'hFF;
    cycles   = 0;
    while ((rem.sum() != 0) && (cycles < 5000)) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      for (int i = 0; i < 8; i++) begin
        if (acc[i]) begin
          sinkq[i].push_back(in_data[i*8 +: 8]);
          rem[i]--;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        if (acc[i]) begin
          if (rem[i] > 0) in_data[i*8 +: 8] = 8'($urandom);
          else            in_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycles++;
    end
    chk("loop_in_budget", int'(cycles < 5000), 1);
    in_valid  = 8'h00;
    out_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) chk("sink_leftover", sinkq[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
